clstm_sequencer: RTL



---
 rtl/clstm_pkg.sv | 27 ++
 rtl/clstm_onehot_dec.sv | 21 ++
 rtl/clstm_sequencer.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/clstm_pkg.sv
// rtl/clstm_pkg.sv - shared state encoding and bank-count defaults for the C-LSTM sequencer
package clstm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD_S1 = 3'd1,
        ST_LOAD_S2 = 3'd2,
        ST_LOAD_S3 = 3'd3,
        ST_START   = 3'd4,
        ST_RUN     = 3'd5,
        ST_DONE    = 3'd6
    } clstm_seq_state_t;

    localparam int CLSTM_S1_BANKS = 8;
    localparam int CLSTM_S2_BANKS = 7;
    localparam int CLSTM_S3_BANKS = 2;

    // Bank index width wide enough for the largest of the three stages.
    function automatic int clstm_idx_w(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/clstm_onehot_dec.sv
// rtl/clstm_onehot_dec.sv - binary index to one-hot bank enable decoder with enable
module clstm_onehot_dec #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic [W-1:0] idx_i,
    input  logic         en_i,
    output logic [N-1:0] onehot_o
);

    // Exactly one bit high when enabled; an out-of-range index yields all zeros.
    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            for (int i = 0; i < N; i++) begin
                if (idx_i == W'(i)) onehot_o[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/clstm_sequencer.sv
// rtl/clstm_sequencer.sv - weight-load, start and stream-count control FSM for the C-LSTM datapath
module clstm_sequencer
    import clstm_pkg::*;
#(
    parameter int S1_BANKS = CLSTM_S1_BANKS,
    parameter int S2_BANKS = CLSTM_S2_BANKS,
    parameter int S3_BANKS = CLSTM_S3_BANKS,
    parameter int STEP_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_start,
    input  logic [STEP_W-1:0]   num_steps,
    output logic                busy,
    output logic                done,
    input  logic                w_valid,
    output logic                w_ready,
    output logic [S1_BANKS-1:0] wen_stage1,
    output logic [S2_BANKS-1:0] wen_stage2,
    output logic [S3_BANKS-1:0] wen_stage3,
    output logic                start_compute,
    input  logic                x_valid,
    output logic                x_ready,
    output logic                dp_i_valid,
    input  logic                dp_o_ready,
    input  logic                dp_o_valid,
    output logic                dp_i_ready,
    input  logic                res_ready,
    output logic                res_valid
);

    localparam int BANK_W = clstm_idx_w(S1_BANKS, S2_BANKS, S3_BANKS);
    localparam logic [BANK_W-1:0] S1_LAST = BANK_W'(S1_BANKS - 1);
    localparam logic [BANK_W-1:0] S2_LAST = BANK_W'(S2_BANKS - 1);
    localparam logic [BANK_W-1:0] S3_LAST = BANK_W'(S3_BANKS - 1);

    clstm_seq_state_t    state_q;
    logic [BANK_W-1:0]   bank_q;
    logic [BANK_W-1:0]   bank_d;
    logic [STEP_W-1:0]   steps_q;
    logic [STEP_W-1:0]   in_cnt_q;
    logic [STEP_W-1:0]   in_cnt_d;
    logic [STEP_W-1:0]   out_cnt_q;
    logic [STEP_W-1:0]   out_cnt_d;

    logic in_load;
    logic w_beat;
    logic in_open;
    logic in_hs;
    logic out_hs;

    assign in_load  = (state_q == ST_LOAD_S1) || (state_q == ST_LOAD_S2) || (state_q == ST_LOAD_S3);
    assign w_beat   = w_valid && in_load;
    assign in_open  = (state_q == ST_RUN) && (in_cnt_q < steps_q);
    assign in_hs    = x_valid && dp_o_ready && in_open;
    assign out_hs   = dp_o_valid && res_ready && (state_q == ST_RUN);

    assign bank_d    = bank_q + BANK_W'(1);
    assign in_cnt_d  = in_cnt_q + STEP_W'(1);
    assign out_cnt_d = out_cnt_q + STEP_W'(1);

    // Status and handshake outputs decode the registered state directly.
    assign busy          = (state_q != ST_IDLE);
    assign done          = (state_q == ST_DONE);
    assign start_compute = (state_q == ST_START);
    assign w_ready       = in_load;
    assign dp_i_valid    = x_valid && in_open;
    assign x_ready       = dp_o_ready && in_open;
    // Results pass straight through in every state; only RUN counts them.
    assign res_valid     = dp_o_valid;
    assign dp_i_ready    = res_ready;

    clstm_onehot_dec #(.N(S1_BANKS), .W(BANK_W)) u_dec_s1 (
        .idx_i    (bank_q),
        .en_i     (w_beat && (state_q == ST_LOAD_S1)),
        .onehot_o (wen_stage1)
    );

    clstm_onehot_dec #(.N(S2_BANKS), .W(BANK_W)) u_dec_s2 (
        .idx_i    (bank_q),
        .en_i     (w_beat && (state_q == ST_LOAD_S2)),
        .onehot_o (wen_stage2)
    );

    clstm_onehot_dec #(.N(S3_BANKS), .W(BANK_W)) u_dec_s3 (
        .idx_i    (bank_q),
        .en_i     (w_beat && (state_q == ST_LOAD_S3)),
        .onehot_o (wen_stage3)
    );

    // Sequencer FSM: bank walk per stage, one-cycle start, counted run, one-cycle done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bank_q    <= '0;
            steps_q   <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_start) begin
                        state_q   <= ST_LOAD_S1;
                        steps_q   <= num_steps;
                        bank_q    <= '0;
                        in_cnt_q  <= '0;
                        out_cnt_q <= '0;
                    end
                end
                ST_LOAD_S1: begin
                    if (w_beat) begin
                        if (bank_q == S1_LAST) begin
                            bank_q  <= '0;
                            state_q <= ST_LOAD_S2;
                        end else begin
                            bank_q <= bank_d;
                        end
                    end
                end
                ST_LOAD_S2: begin
                    if (w_beat) begin
                        if (bank_q == S2_LAST) begin
                            bank_q  <= '0;
                            state_q <= ST_LOAD_S3;
                        end else begin
                            bank_q <= bank_d;
                        end
                    end
                end
                ST_LOAD_S3: begin
                    if (w_beat) begin
                        if (bank_q == S3_LAST) begin
                            bank_q  <= '0;
                            state_q <= ST_START;
                        end else begin
                            bank_q <= bank_d;
                        end
                    end
                end
                ST_START: begin
                    state_q <= (steps_q != '0) ? ST_RUN : ST_DONE;
                end
                ST_RUN: begin
                    if (in_hs) in_cnt_q <= in_cnt_d;
                    if (out_hs) begin
                        out_cnt_q <= out_cnt_d;
                        if (out_cnt_d == steps_q) state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
